goe_mport: RTL and testbench

- Multi-port successor to the single-output global output engine. Sits at the pipeline tail and forwards 134-bit FAST packet words (metadata head word first) to one or more output ports.
- Each packet's destination ports come from a one-hot bitmap carried in its head word.
- Destinations that are almost-full are masked per packet. Packets left with no destination are dropped whole.
- Forwarded and dropped packets are counted in saturating counters.

---
 rtl/goe_mport.sv | 138 +++++++++++++
 tb/tb_goe_mport.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/goe_mport.sv
// Multi-port global output engine: forwards FAST packet words to the ports
// selected by the head-word bitmap, masking almost-full ports and dropping empty packets.
module goe_mport #(
  parameter int          DATA_WIDTH  = 134,
  parameter int          N_PORTS     = 4,
  parameter int          OUTPORT_LSB = 88,
  parameter int          CNT_WIDTH   = 32,
  parameter logic [7:0]  LMID        = 8'd5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_goe_data_wr,
  input  logic [DATA_WIDTH-1:0] in_goe_data,
  input  logic                  in_goe_valid_wr,
  input  logic                  in_goe_valid,
  input  logic [N_PORTS-1:0]    out_port_alf,
  input  logic                  cnt_clr,
  output logic [N_PORTS-1:0]    pktout_data_wr,
  output logic [DATA_WIDTH-1:0] pktout_data,
  output logic [N_PORTS-1:0]    pktout_data_valid_wr,
  output logic                  pktout_data_valid,
  output logic [CNT_WIDTH-1:0]  tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, TRANS, DROP} state_e;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  state_e                  state_q, state_d;
  logic [N_PORTS-1:0]      mask_q, mask_d;
  logic [N_PORTS-1:0]      data_wr_q, data_wr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [N_PORTS-1:0]      valid_wr_q, valid_wr_d;
  logic                    valid_q, valid_d;
  logic [CNT_WIDTH-1:0]    tx_cnt_q, tx_cnt_d;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

  logic [1:0]              tag;
  logic                    is_head, is_tail;
  logic [N_PORTS-1:0]      head_mask;
  logic                    fwd_ctx;
  logic [N_PORTS-1:0]      fwd_mask;
  logic                    tx_inc, drop_inc;

  assign tag       = in_goe_data[DATA_WIDTH-1:DATA_WIDTH-2];
  assign is_head   = in_goe_data_wr && (tag == TAG_HEAD);
  assign is_tail   = in_goe_data_wr && (tag == TAG_TAIL);
  assign head_mask = in_goe_data[OUTPORT_LSB +: N_PORTS] & ~out_port_alf;

  // A head word always restarts packet processing, even mid-packet (malformed input).
  assign fwd_ctx  = is_head ? (head_mask != '0) : (state_q == TRANS);
  assign fwd_mask = is_head ? head_mask : mask_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d    = state_q;
    mask_d     = mask_q;
    data_wr_d  = '0;
    data_d     = '0;
    valid_wr_d = '0;
    valid_d    = 1'b0;
    tx_inc     = 1'b0;
    drop_inc   = 1'b0;

    if (is_head) begin
      mask_d  = head_mask;
      state_d = (head_mask != '0) ? TRANS : DROP;
      if (head_mask != '0) begin
        data_wr_d = head_mask;
        data_d    = in_goe_data;
      end
    end else if (in_goe_data_wr) begin
      unique case (state_q)
        TRANS: begin
          data_wr_d = mask_q;
          data_d    = in_goe_data;
          if (is_tail) begin
            state_d = IDLE;
            tx_inc  = 1'b1;
          end
        end
        DROP: begin
          if (is_tail) begin
            state_d  = IDLE;
            drop_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (in_goe_valid_wr && fwd_ctx) begin
      valid_wr_d = fwd_mask;
      valid_d    = in_goe_valid;
    end

    tx_cnt_d = tx_cnt_q;
    if (cnt_clr)                          tx_cnt_d = '0;
    else if (tx_inc && tx_cnt_q != '1)    tx_cnt_d = tx_cnt_q + 1'b1;

    drop_cnt_d = drop_cnt_q;
    if (cnt_clr)                          drop_cnt_d = '0;
    else if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      data_wr_q  <= '0;
      data_q     <= '0;
      valid_wr_q <= '0;
      valid_q    <= 1'b0;
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q    <= state_d;
      mask_q     <= mask_d;
      data_wr_q  <= data_wr_d;
      data_q     <= data_d;
      valid_wr_q <= valid_wr_d;
      valid_q    <= valid_d;
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pktout_data_wr       = data_wr_q;
  assign pktout_data          = data_q;
  assign pktout_data_valid_wr = valid_wr_q;
  assign pktout_data_valid    = valid_q;
  assign tx_pkt_cnt           = tx_cnt_q;
  assign drop_pkt_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_goe_mport.sv
// Directed self-checking bench for goe_mport (4 ports, 4-bit counters so saturation is reachable).
module tb_goe_mport;

  localparam int DW  = 134;
  localparam int NP  = 4;
  localparam int CW  = 4;

  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] M = 2'b11;
  localparam logic [1:0] T = 2'b10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_goe_data_wr;
  logic [DW-1:0]  in_goe_data;
  logic           in_goe_valid_wr;
  logic           in_goe_valid;
  logic [NP-1:0]  out_port_alf;
  logic           cnt_clr;
  logic [NP-1:0]  pktout_data_wr;
  logic [DW-1:0]  pktout_data;
  logic [NP-1:0]  pktout_data_valid_wr;
  logic           pktout_data_valid;
  logic [CW-1:0]  tx_pkt_cnt;
  logic [CW-1:0]  drop_pkt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  goe_mport #(.DATA_WIDTH(DW), .N_PORTS(NP), .OUTPORT_LSB(88), .CNT_WIDTH(CW), .LMID(8'd5)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_goe_data_wr       (in_goe_data_wr),
    .in_goe_data          (in_goe_data),
    .in_goe_valid_wr      (in_goe_valid_wr),
    .in_goe_valid         (in_goe_valid),
    .out_port_alf         (out_port_alf),
    .cnt_clr              (cnt_clr),
    .pktout_data_wr       (pktout_data_wr),
    .pktout_data          (pktout_data),
    .pktout_data_valid_wr (pktout_data_valid_wr),
    .pktout_data_valid    (pktout_data_valid),
    .tx_pkt_cnt           (tx_pkt_cnt),
    .drop_pkt_cnt         (drop_pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input logic [1:0] tag, input logic [3:0] bmp,
                                            input logic [7:0] id);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1:DW-2] = tag;
    w[91:88]     = bmp;
    w[67:60]     = ~id;
    w[7:0]       = id;
    return w;
  endfunction

  // Drives one input word for one cycle and checks the registered output one cycle later.
  task automatic word(input string name, input logic [1:0] tag, input logic [3:0] bmp,
                      input logic [7:0] id, input logic [3:0] alf, input logic vwr,
                      input logic v, input logic [3:0] exp_wr, input logic [3:0] exp_vwr,
                      input logic exp_v);
    logic [DW-1:0] w;
    w = mk_word(tag, bmp, id);
    @(negedge clk);
    in_goe_data_wr  = 1'b1;
    in_goe_data     = w;
    in_goe_valid_wr = vwr;
    in_goe_valid    = v;
    out_port_alf    = alf;
    @(posedge clk);
    #1;
    check({name, ".wr"},   DW'(pktout_data_wr), DW'(exp_wr));
    check({name, ".data"}, pktout_data, (exp_wr != 4'b0) ? w : '0);
    check({name, ".vwr"},  DW'(pktout_data_valid_wr), DW'(exp_vwr));
    check({name, ".v"},    DW'(pktout_data_valid), DW'(exp_v));
    @(negedge clk);
    in_goe_data_wr  = 1'b0;
    in_goe_data     = '0;
    in_goe_valid_wr = 1'b0;
    in_goe_valid    = 1'b0;
  endtask

  task automatic idle_check(input string name);
    @(posedge clk);
    #1;
    check({name, ".wr"},   DW'(pktout_data_wr), '0);
    check({name, ".data"}, pktout_data, '0);
    check({name, ".vwr"},  DW'(pktout_data_valid_wr), '0);
  endtask

  // Minimal head+tail packet to port 0, forwarded.
  task automatic short_pkt(input logic [7:0] id);
    word("sp_h", H, 4'b0001, id, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    word("sp_t", T, 4'b0000, id, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_goe_data_wr = 1'b0; in_goe_data = '0; in_goe_valid_wr = 1'b0;
    in_goe_valid = 1'b0; out_port_alf = '0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.wr",   DW'(pktout_data_wr), '0);
    check("rst.vwr",  DW'(pktout_data_valid_wr), '0);
    check("rst.data", pktout_data, '0);
    check("rst.tx",   DW'(tx_pkt_cnt), '0);
    check("rst.drop", DW'(drop_pkt_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unicast with a gap mid-packet
    word("uc_h", H, 4'b0010, 8'h10, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0);
    word("uc_m", M, 4'b0000, 8'h11, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0);
    idle_check("uc_gap");
    word("uc_t", T, 4'b0000, 8'h12, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b1);
    check("uc.tx", DW'(tx_pkt_cnt), DW'(1));

    // Multicast with masking latched at the head; bad-packet valid value
    word("mc_h", H, 4'b1011, 8'h20, 4'b0001, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b0);
    word("mc_m", M, 4'b0000, 8'h21, 4'b1111, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b0);
    word("mc_t", T, 4'b0000, 8'h22, 4'b1111, 1'b1, 1'b0, 4'b1010, 4'b1010, 1'b0);
    check("mc.tx", DW'(tx_pkt_cnt), DW'(2));

    // Drop: every destination almost-full, 5 words, valid_wr suppressed
    word("dr_h",  H, 4'b0100, 8'h30, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    word("dr_m1", M, 4'b0000, 8'h31, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    word("dr_m2", M, 4'b0000, 8'h32, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    word("dr_m3", M, 4'b0000, 8'h33, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    word("dr_t",  T, 4'b0000, 8'h34, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    check("dr.drop", DW'(drop_pkt_cnt), DW'(1));
    check("dr.tx",   DW'(tx_pkt_cnt), DW'(2));
    // Empty bitmap drops too
    word("dz_h", H, 4'b0000, 8'h38, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    word("dz_t", T, 4'b0000, 8'h39, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    check("dz.drop", DW'(drop_pkt_cnt), DW'(2));
    short_pkt(8'h3A);
    check("dr.next_tx", DW'(tx_pkt_cnt), DW'(3));

    // Orphan, then truncated packet A overtaken by head B
    word("or_m", M, 4'b0000, 8'h40, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    word("a_h",  H, 4'b0001, 8'h41, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    word("a_m",  M, 4'b0000, 8'h42, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    word("b_h",  H, 4'b0100, 8'h43, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0);
    word("b_t",  T, 4'b0000, 8'h44, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1);
    check("mal.tx",   DW'(tx_pkt_cnt), DW'(4));
    check("mal.drop", DW'(drop_pkt_cnt), DW'(2));

    // Saturation: 11 more packets reach 4'hF, then 2 more must not wrap
    for (int i = 0; i < 11; i++) short_pkt(8'h50 + 8'(i));
    check("sat.tx15", DW'(tx_pkt_cnt), DW'(15));
    short_pkt(8'h60);
    short_pkt(8'h61);
    check("sat.hold", DW'(tx_pkt_cnt), DW'(15));
    // cnt_clr coincident with an emitted tail
    word("clr_h", H, 4'b0001, 8'h62, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    cnt_clr = 1'b1;
    word("clr_t", T, 4'b0000, 8'h63, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1);
    cnt_clr = 1'b0;
    check("clr.tx",   DW'(tx_pkt_cnt), '0);
    check("clr.drop", DW'(drop_pkt_cnt), '0);
    short_pkt(8'h64);
    check("clr.inc", DW'(tx_pkt_cnt), DW'(1));
    // Clear beats increment when not saturated
    word("clr2_h", H, 4'b0001, 8'h65, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    cnt_clr = 1'b1;
    word("clr2_t", T, 4'b0000, 8'h66, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1);
    cnt_clr = 1'b0;
    check("clr2.tx", DW'(tx_pkt_cnt), '0);
    short_pkt(8'h67);

    // Reset after the 2nd word of a 4-word packet
    word("rs_h", H, 4'b1000, 8'h70, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0);
    word("rs_m", M, 4'b0000, 8'h71, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0);
    @(negedge clk);
    in_goe_data_wr = 1'b1;
    in_goe_data    = mk_word(M, 4'b0000, 8'h7F);
    rst_n = 1'b0;
    #1;
    check("rs.wr",   DW'(pktout_data_wr), '0);
    check("rs.data", pktout_data, '0);
    check("rs.vwr",  DW'(pktout_data_valid_wr), '0);
    check("rs.v",    DW'(pktout_data_valid), '0);
    check("rs.tx",   DW'(tx_pkt_cnt), '0);
    @(posedge clk);
    #1;
    check("rs.hold_wr", DW'(pktout_data_wr), '0);
    @(negedge clk);
    in_goe_data_wr = 1'b0;
    in_goe_data    = '0;
    rst_n = 1'b1;
    word("rs_m2", M, 4'b0000, 8'h72, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    word("rs_t",  T, 4'b0000, 8'h73, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    check("rs.tx_after", DW'(tx_pkt_cnt), '0);
    word("nw_h", H, 4'b0110, 8'h80, 4'b0000, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0);
    word("nw_t", T, 4'b0000, 8'h81, 4'b0000, 1'b1, 1'b1, 4'b0110, 4'b0110, 1'b1);
    check("nw.tx", DW'(tx_pkt_cnt), DW'(1));
    idle_check("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
